// File: rtl/rv32i_fetch_if.sv
// Instruction-memory read bus for the RV32I fetch unit (Avalon-MM style, read only).
//   imem_addr          word-aligned read address, driven by the master
//   imem_read          read request, driven by the master
//   imem_waitrequest   slave cannot accept the request this cycle
//   imem_readdata      returned instruction word
//   imem_readdatavalid imem_readdata valid; returns are in request order
// Modports: master (fetch unit) and slave (memory).
interface rv32i_fetch_if;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic        imem_waitrequest;
    logic [31:0] imem_readdata;
    logic        imem_readdatavalid;

    modport master (
        output imem_addr,
        output imem_read,
        input  imem_waitrequest,
        input  imem_readdata,
        input  imem_readdatavalid
    );

    modport slave (
        input  imem_addr,
        input  imem_read,
        output imem_waitrequest,
        output imem_readdata,
        output imem_readdatavalid
    );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch unit.
// Issues pipelined reads over the imem bus, buffers returned words in a 2-entry queue and
// presents one registered instruction/PC pair per cycle to the decoder.
//   clk          system clock
//   reset        asynchronous, active-high reset
//   imem         instruction memory bus (master side)
//   stall        hold the current output instruction
//   update_pc    redirect request from execute; overrides stall
//   new_pc       redirect target, bits [1:0] ignored
//   instr        instruction to decoder, RV32I_NOP when instr_valid=0
//   pc           address of instr
//   instr_valid  instr/pc hold a real fetched instruction
module rv32i_fetch #(
    parameter logic [31:0] RV32I_RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] RV32I_NOP          = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32i_fetch_if.master        imem,
    input  logic                 stall,
    input  logic                 update_pc,
    input  logic [31:0]          new_pc,
    output logic [31:0]          instr,
    output logic [31:0]          pc,
    output logic                 instr_valid
);

    typedef enum logic [1:0] {StReset, StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic            read_q, read_d;
    logic [31:0]     addr_q, addr_d;            // address on the bus
    logic [31:0]     fetch_addr_q, fetch_addr_d; // next address of the live stream
    logic [1:0]      outstanding_q, outstanding_d;
    logic [1:0]      discard_q, discard_d;
    logic [1:0]      count_q, count_d;
    logic [1:0][31:0] buf_instr_q, buf_instr_d;
    logic [1:0][31:0] buf_pc_q, buf_pc_d;
    logic [31:0]     ret_pc_q, ret_pc_d;        // pc of the next kept return
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     pc_q, pc_d;
    logic            valid_q, valid_d;

    logic [31:0] target;
    logic        accept, held, ret, ret_drop, ret_keep, acc_live;
    logic        pop, bypass, push, wr_slot;
    logic [1:0]  out_next, disc_next;

    assign target   = new_pc & ~32'h3;
    assign accept   = read_q & ~imem.imem_waitrequest;
    assign held     = read_q & imem.imem_waitrequest;
    // Returns seen in StReset belong to a transfer abandoned by reset.
    assign ret      = imem.imem_readdatavalid & (state_q != StReset);
    assign ret_drop = ret & (discard_q != 2'd0);
    assign ret_keep = ret & (discard_q == 2'd0);
    // Accepts outside StRun are held requests already counted in discard.
    assign acc_live = accept & (state_q == StRun);
    assign out_next  = outstanding_q + {1'b0, acc_live} - {1'b0, ret_keep};
    assign disc_next = discard_q - {1'b0, ret_drop};

    assign pop     = ~update_pc & ~stall & (count_q != 2'd0);
    assign bypass  = ~update_pc & ~stall & (count_q == 2'd0) & ret_keep;
    assign push    = ~update_pc & ret_keep & ~bypass;
    assign wr_slot = pop ? (count_q == 2'd2) : (count_q != 2'd0);

    always_comb begin
        state_d       = state_q;
        read_d        = read_q;
        fetch_addr_d  = fetch_addr_q;
        outstanding_d = out_next;
        discard_d     = disc_next;
        count_d       = count_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        ret_pc_d      = ret_pc_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        valid_d       = valid_q;

        if (acc_live) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end

        if (update_pc) begin
            count_d       = 2'd0;
            instr_d       = RV32I_NOP;
            valid_d       = 1'b0;
            pc_d          = target;
            ret_pc_d      = target;
            fetch_addr_d  = target;
            outstanding_d = 2'd0;
            // Everything still in flight becomes discard; a request held on the bus in
            // StRun is new to the count, in StFlush it was counted by the earlier redirect.
            discard_d     = disc_next + out_next + {1'b0, held & (state_q == StRun)};
            read_d        = held | (discard_d == 2'd0);
            state_d       = (discard_d != 2'd0) ? StFlush : StRun;
        end else begin
            if (ret_keep) begin
                ret_pc_d = ret_pc_q + 32'd4;
            end
            if (!stall) begin
                if (pop) begin
                    instr_d = buf_instr_q[0];
                    pc_d    = buf_pc_q[0];
                    valid_d = 1'b1;
                end else if (bypass) begin
                    instr_d = imem.imem_readdata;
                    pc_d    = ret_pc_q;
                    valid_d = 1'b1;
                end else begin
                    instr_d = RV32I_NOP;
                    valid_d = 1'b0;
                end
            end
            if (pop) begin
                buf_instr_d[0] = buf_instr_q[1];
                buf_pc_d[0]    = buf_pc_q[1];
            end
            if (push) begin
                buf_instr_d[wr_slot] = imem.imem_readdata;
                buf_pc_d[wr_slot]    = ret_pc_q;
            end
            count_d = count_q - {1'b0, pop} + {1'b0, push};

            unique case (state_q)
                StReset: begin
                    read_d  = 1'b1;
                    state_d = StRun;
                end
                StRun: begin
                    // Credit rule keeps buffered + in-flight words within the 2 buffer slots.
                    read_d = held | (({1'b0, count_d} + {1'b0, out_next}) < 3'd2);
                end
                StFlush: begin
                    if (disc_next == 2'd0 && !held) begin
                        read_d  = 1'b1;
                        state_d = StRun;
                    end else begin
                        read_d = held;
                    end
                end
                default: begin
                    read_d  = 1'b0;
                    state_d = StReset;
                end
            endcase
        end

        // A request under waitrequest keeps its address until accepted.
        addr_d = held ? addr_q : fetch_addr_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StReset;
            read_q        <= 1'b0;
            addr_q        <= RV32I_RESET_VECTOR;
            fetch_addr_q  <= RV32I_RESET_VECTOR;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
            count_q       <= 2'd0;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
            ret_pc_q      <= RV32I_RESET_VECTOR;
            instr_q       <= RV32I_NOP;
            pc_q          <= RV32I_RESET_VECTOR;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            read_q        <= read_d;
            addr_q        <= addr_d;
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            ret_pc_q      <= ret_pc_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
        end
    end

    assign imem.imem_read = read_q;
    assign imem.imem_addr = addr_q;
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign instr_valid    = valid_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: directed scenarios plus a randomized run against a
// program-order model (expected pc stream, memory contents, request stream, flush rules).
module tb_rv32i_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, update_pc;
    logic [31:0] new_pc, instr, pc;
    logic        instr_valid;

    always #5 clk = ~clk;

    rv32i_fetch_if bus ();

    rv32i_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .stall       (stall),
        .update_pc   (update_pc),
        .new_pc      (new_pc),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid)
    );

    int n_checks, n_errors;
    int cyc;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t mq[$];
    int   last_due;
    int   lat_min, lat_max, wait_pct;
    bit   force_wait, stray;
    logic [31:0] wait_addr;

    // Program-order model state.
    logic [31:0] exp_pc, req_exp, held_addr, p_instr, p_pc, p_npc, p_addr, hold_pc;
    bit          p_valid, p_stall, p_upd, p_held, skip_held;
    int          inflight, old_pending, retired;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        last_due    = 0;
        exp_pc      = 32'h0;
        req_exp     = 32'h0;
        skip_held   = 0;
        inflight    = 0;
        old_pending = 0;
        p_valid     = 0;
        p_instr     = NOP;
        p_pc        = 32'h0;
        p_stall     = 0;
        p_upd       = 0;
        p_held      = 0;
    endtask

    // Sampled at the falling edge: outputs are the result of the previous rising edge,
    // inputs are what the next rising edge will see.
    task automatic mon();
        bit acc, held_now;
        int lat, due;
        if (p_upd) begin
            check_eq("redir_valid", 32'(instr_valid), 32'd0);
            check_eq("redir_instr", instr, NOP);
            check_eq("redir_pc", pc, p_npc & ~32'h3);
            exp_pc = p_npc & ~32'h3;
        end else if (p_stall) begin
            check_eq("stall_instr", instr, p_instr);
            check_eq("stall_pc", pc, p_pc);
            check_eq("stall_valid", 32'(instr_valid), 32'(p_valid));
        end else if (instr_valid) begin
            check_eq("stream_pc", pc, exp_pc);
            check_eq("stream_instr", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            retired++;
        end else begin
            check_eq("bubble_instr", instr, NOP);
            check_eq("bubble_pc", pc, p_pc);
        end
        if (p_held) begin
            check_eq("held_read", 32'(bus.imem_read), 32'd1);
            check_eq("held_addr", bus.imem_addr, p_addr);
        end

        acc = bus.imem_read && !bus.imem_waitrequest;
        if (bus.imem_read) check_eq("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
        if (acc) begin
            if (skip_held) begin
                check_eq("held_req_addr", bus.imem_addr, held_addr);
                skip_held = 0;
            end else begin
                check_eq("req_during_flush", 32'(old_pending), 32'd0);
                check_eq("req_addr", bus.imem_addr, req_exp);
                req_exp = req_exp + 32'd4;
            end
            inflight++;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{data: mem_word(bus.imem_addr), due: due});
        end
        if (bus.imem_readdatavalid && !stray) begin
            void'(mq.pop_front());
            inflight--;
            if (old_pending > 0) old_pending--;
        end
        if (update_pc) begin
            held_now    = bus.imem_read && bus.imem_waitrequest;
            old_pending = inflight + (held_now ? 1 : 0);
            if (held_now) begin
                skip_held = 1;
                held_addr = bus.imem_addr;
            end
            req_exp = new_pc & ~32'h3;
        end

        p_valid = instr_valid;
        p_instr = instr;
        p_pc    = pc;
        p_stall = stall;
        p_upd   = update_pc;
        p_npc   = new_pc;
        p_held  = bus.imem_read && bus.imem_waitrequest;
        p_addr  = bus.imem_addr;
    endtask

    task automatic cycle();
        if (force_wait && bus.imem_read && bus.imem_addr == wait_addr)
            bus.imem_waitrequest = 1'b1;
        else
            bus.imem_waitrequest = int'($urandom_range(99)) < wait_pct;
        if (stray) begin
            bus.imem_readdatavalid = 1'b1;
            bus.imem_readdata      = 32'hDEAD_BEEF;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_readdatavalid = 1'b1;
            bus.imem_readdata      = mq[0].data;
        end else begin
            bus.imem_readdatavalid = 1'b0;
            bus.imem_readdata      = $urandom;
        end
        @(negedge clk);
        mon();
        stray = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset                  = 1'b1;
        stall                  = 1'b0;
        update_pc              = 1'b0;
        bus.imem_waitrequest   = 1'b0;
        bus.imem_readdatavalid = 1'b0;
        #1;
        check_eq("rst_read", 32'(bus.imem_read), 32'd0);
        check_eq("rst_addr", bus.imem_addr, 32'h0);
        check_eq("rst_instr", instr, NOP);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        model_reset();
        force_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] want, input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            cycle();
            n++;
        end
        check_eq({tag, "_seen"}, 32'(instr_valid), 32'd1);
        check_eq(tag, pc, want);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        retired  = 0;
        reset    = 1'b1;
        stall    = 1'b0;
        update_pc = 1'b0;
        new_pc   = 32'h0;
        bus.imem_waitrequest   = 1'b0;
        bus.imem_readdatavalid = 1'b0;
        bus.imem_readdata      = 32'h0;
        lat_min  = 1;
        lat_max  = 1;
        wait_pct = 0;
        force_wait = 0;
        stray    = 0;
        wait_addr = 32'h0;
        model_reset();

        // Reset and zero-wait stream; a stray return right after release must be ignored.
        apply_reset();
        stray = 1;
        cycle();
        check_eq("edge1_read", 32'(bus.imem_read), 32'd1);
        check_eq("edge1_addr", bus.imem_addr, 32'h0);
        cycle();
        check_eq("edge2_valid", 32'(instr_valid), 32'd0);
        cycle();
        check_eq("edge3_valid", 32'(instr_valid), 32'd1);
        check_eq("edge3_pc", pc, 32'h0);
        check_eq("edge3_instr", instr, 32'h0010_0093);
        cycle();
        check_eq("edge4_valid", 32'(instr_valid), 32'd1);
        check_eq("edge4_pc", pc, 32'h4);
        check_eq("edge4_instr", instr, 32'h0020_0113);
        cycle();
        check_eq("edge5_pc", pc, 32'h8);
        check_eq("edge5_valid", 32'(instr_valid), 32'd1);

        // Stall for 5 cycles: output holds, requests stop once the buffer is full.
        repeat (3) cycle();
        hold_pc = pc;
        stall = 1'b1;
        repeat (5) cycle();
        check_eq("stall_read_drop", 32'(bus.imem_read), 32'd0);
        check_eq("stall_hold_pc", pc, hold_pc);
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("post_stall_valid", 32'(instr_valid), 32'd1);
        end

        // Redirect with two reads outstanding at latency 3.
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20 && inflight != 2; i++) cycle();
        check_eq("two_outstanding", 32'(inflight), 32'd2);
        update_pc = 1'b1;
        new_pc    = 32'h100;
        cycle();
        update_pc = 1'b0;
        wait_valid("redir_100_pc", 32'h100, 30);

        // Redirect while the request for 0x8 is held under waitrequest.
        lat_min = 1;
        lat_max = 1;
        apply_reset();
        force_wait = 1;
        wait_addr  = 32'h8;
        for (int i = 0; i < 10 && !(bus.imem_read && bus.imem_addr == 32'h8); i++) cycle();
        check_eq("wait_addr8", bus.imem_addr, 32'h8);
        cycle();
        update_pc = 1'b1;
        new_pc    = 32'h203;
        cycle();
        update_pc = 1'b0;
        check_eq("wait_still_read", 32'(bus.imem_read), 32'd1);
        check_eq("wait_still_addr", bus.imem_addr, 32'h8);
        repeat (2) cycle();
        force_wait = 0;
        wait_valid("redir_200_pc", 32'h200, 30);

        // Simultaneous stall and redirect with a valid instruction at 0x10.
        update_pc = 1'b1;
        new_pc    = 32'h10;
        cycle();
        update_pc = 1'b0;
        wait_valid("pc10", 32'h10, 30);
        stall     = 1'b1;
        update_pc = 1'b1;
        new_pc    = 32'h40;
        cycle();
        stall     = 1'b0;
        update_pc = 1'b0;
        check_eq("stallredir_instr", instr, NOP);
        check_eq("stallredir_valid", 32'(instr_valid), 32'd0);
        check_eq("stallredir_pc", pc, 32'h40);
        wait_valid("pc40", 32'h40, 30);

        // Address wrap, then asynchronous reset in the middle of streaming.
        update_pc = 1'b1;
        new_pc    = 32'hFFFF_FFFE;
        cycle();
        update_pc = 1'b0;
        wait_valid("wrap_top", 32'hFFFF_FFFC, 30);
        cycle();
        check_eq("wrap_valid", 32'(instr_valid), 32'd1);
        check_eq("wrap_pc", pc, 32'h0);
        cycle();
        apply_reset();

        // Randomized run: latency 1..4, waitrequest, stalls and redirects.
        lat_min  = 1;
        lat_max  = 4;
        wait_pct = 30;
        retired  = 0;
        for (int i = 0; i < 2500; i++) begin
            stall     = $urandom_range(99) < 25;
            update_pc = $urandom_range(99) < 4;
            new_pc    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            cycle();
        end
        stall     = 1'b0;
        update_pc = 1'b0;
        repeat (10) cycle();
        check_eq("random_progress", 32'(retired >= 150), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
